// File: rtl/avalon_mem_arbiter_pkg.sv
// Shared types for the fetch / load-store Avalon-MM arbiter.
// State encoding, grant owner and the fetch abort instruction.
package avalon_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_CMD,
    I_DATA,
    D_RCMD,
    D_RDATA,
    D_WCMD,
    DONE
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/avalon_mem_arbiter_req_pending.sv
// Rising-edge request capture with a sticky pending flag.
// A fresh edge in the clearing cycle wins, so it is never lost.
module req_pending (
  input  logic CLK,
  input  logic RST,
  input  logic req,
  input  logic mask,
  input  logic clr,
  output logic rise,
  output logic pending
);

  logic req_q;

  assign rise = req & ~req_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      req_q   <= req;
      pending <= (rise & ~mask) | (pending & ~clr);
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Shares one Avalon-MM master between instruction fetch and data access,
// with alternating priority on contention, a wait timeout and sticky errors.
module avalon_mem_arbiter
  import avalon_mem_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_done,
  input  logic            d_rd,
  input  logic            d_wr,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic [AW-1:0]   avm_address,
  output logic            avm_read,
  output logic            avm_write,
  output logic [DW-1:0]   avm_writedata,
  output logic [DW/8-1:0] avm_byteenable,
  input  logic [DW-1:0]   avm_readdata,
  input  logic            avm_readdatavalid,
  input  logic            avm_waitrequest,
  output logic [1:0]      err
);

  localparam int WW = (MAX_WAIT <= 1) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WW-1:0] LIMIT =
    WW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);
  localparam bit TO_EN = (MAX_WAIT != 0);

  arb_state_t state, state_nxt;
  grant_t     last_grant, cur_grant;
  logic       cur_wr;
  logic [WW-1:0] wait_cnt;

  logic i_rise, i_pend, clr_i;
  logic r_rise, r_pend, clr_r;
  logic w_rise, w_pend, clr_w;

  logic d_pend, pick_data, timeout;
  logic take_grant, grab_i, grab_d;
  logic abort, abort_i, abort_d;

  req_pending u_ireq (
    .CLK     (CLK),
    .RST     (RST),
    .req     (i_req),
    .mask    (1'b0),
    .clr     (clr_i),
    .rise    (i_rise),
    .pending (i_pend)
  );

  // A read edge coinciding with a write edge is dropped.
  req_pending u_drd (
    .CLK     (CLK),
    .RST     (RST),
    .req     (d_rd),
    .mask    (w_rise),
    .clr     (clr_r),
    .rise    (r_rise),
    .pending (r_pend)
  );

  req_pending u_dwr (
    .CLK     (CLK),
    .RST     (RST),
    .req     (d_wr),
    .mask    (1'b0),
    .clr     (clr_w),
    .rise    (w_rise),
    .pending (w_pend)
  );

  assign d_pend    = r_pend | w_pend;
  assign pick_data = d_pend & (~i_pend | (last_grant == INSTR));
  assign timeout   = TO_EN && (wait_cnt == LIMIT);

  assign avm_read  = (state == I_CMD) || (state == D_RCMD);
  assign avm_write = (state == D_WCMD);
  assign i_done    = (state == DONE) && (cur_grant == INSTR);
  assign d_done    = (state == DONE) && (cur_grant == DATA);

  assign clr_i = i_done;
  assign clr_r = d_done & ~cur_wr;
  assign clr_w = d_done & cur_wr;

  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    grab_i     = 1'b0;
    grab_d     = 1'b0;
    abort_i    = 1'b0;
    abort_d    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_data) begin
          take_grant = 1'b1;
          state_nxt  = w_pend ? D_WCMD : D_RCMD;
        end else if (i_pend) begin
          take_grant = 1'b1;
          state_nxt  = I_CMD;
        end
      end
      I_CMD: begin
        if (!avm_waitrequest && avm_readdatavalid) begin
          grab_i    = 1'b1;
          state_nxt = DONE;
        end else if (timeout) begin
          abort_i   = 1'b1;
          state_nxt = DONE;
        end else if (!avm_waitrequest) begin
          state_nxt = I_DATA;
        end
      end
      I_DATA: begin
        if (avm_readdatavalid) begin
          grab_i    = 1'b1;
          state_nxt = DONE;
        end else if (timeout) begin
          abort_i   = 1'b1;
          state_nxt = DONE;
        end
      end
      D_RCMD: begin
        if (!avm_waitrequest && avm_readdatavalid) begin
          grab_d    = 1'b1;
          state_nxt = DONE;
        end else if (timeout) begin
          abort_d   = 1'b1;
          state_nxt = DONE;
        end else if (!avm_waitrequest) begin
          state_nxt = D_RDATA;
        end
      end
      D_RDATA: begin
        if (avm_readdatavalid) begin
          grab_d    = 1'b1;
          state_nxt = DONE;
        end else if (timeout) begin
          abort_d   = 1'b1;
          state_nxt = DONE;
        end
      end
      D_WCMD: begin
        if (!avm_waitrequest) begin
          state_nxt = DONE;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      last_grant     <= INSTR;
      cur_grant      <= INSTR;
      cur_wr         <= 1'b0;
      wait_cnt       <= '0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      i_rdata        <= '0;
      d_rdata        <= '0;
      err            <= 2'b00;
    end else begin
      state <= state_nxt;
      if (take_grant) begin
        wait_cnt       <= '0;
        cur_grant      <= pick_data ? DATA : INSTR;
        cur_wr         <= pick_data & w_pend;
        avm_address    <= pick_data ? d_addr : i_addr;
        avm_writedata  <= (pick_data & w_pend) ? d_wdata : '0;
        avm_byteenable <= (pick_data & w_pend) ? d_be : '1;
      end else if (state != IDLE && state != DONE) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
      if (grab_i)  i_rdata <= avm_readdata;
      if (grab_d)  d_rdata <= avm_readdata;
      // An abandoned fetch must still hand the core something harmless.
      if (abort_i) i_rdata <= DW'(RV_NOP);
      if (abort_d) d_rdata <= '0;
      if (abort | abort_i | abort_d) err[0] <= 1'b1;
      if (r_rise & w_rise) err[1] <= 1'b1;
      if (state == DONE) last_grant <= cur_grant;
    end
  end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter: latency, waits, arbitration,
// level requests, timeout, mid-transfer reset and rd/wr conflict.
module tb_avalon_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
  logic [1:0]  err;

  int n_cmp = 0;
  int n_bad = 0;

  avalon_mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(8)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .i_req             (i_req),
    .i_addr            (i_addr),
    .i_rdata           (i_rdata),
    .i_done            (i_done),
    .d_rd              (d_rd),
    .d_wr              (d_wr),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_be              (d_be),
    .d_rdata           (d_rdata),
    .d_done            (d_done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .err               (err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    avm_readdata = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  // Zero-wait slave: waits for a read strobe, accepts it,
  // returns data the following cycle; leaves us in the DONE cycle.
  task automatic serve_read(input logic [31:0] data,
                            output logic [31:0] addr,
                            output bit ok);
    ok = 1'b0;
    addr = '0;
    for (int k = 0; k < 20; k++) begin
      if (avm_read) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      addr = avm_address;
      tick();
      avm_readdatavalid = 1'b1;
      avm_readdata = data;
      tick();
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
    end
  endtask

  task automatic test_reset();
    logic [139:0] all;
    RST = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    tick(); tick(); tick();
    all = {avm_address, avm_writedata, i_rdata, d_rdata,
           avm_byteenable, avm_read, avm_write,
           i_done, d_done, err};
    n_cmp++;
    if (all !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", all);
    end
    RST = 1'b0;
    tick();
    n_cmp++;
    if ({avm_read, avm_write, i_done, d_done} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want 0000",
               {avm_read, avm_write, i_done, d_done});
    end
  endtask

  task automatic test_fetch();
    i_addr = 32'h40;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    tick();
    n_cmp++;
    if (avm_read !== 1'b1 || avm_address !== 32'h40) begin
      n_bad++;
      $display("FAIL fetch_cmd: got rd=%b addr=%h want rd=1 addr=40",
               avm_read, avm_address);
    end
    tick();
    n_cmp++;
    if (avm_read !== 1'b0 || i_done !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_strobe_len: got rd=%b done=%b want 0 0",
               avm_read, i_done);
    end
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0050_0093;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    n_cmp++;
    if (i_done !== 1'b1 || i_rdata !== 32'h0050_0093) begin
      n_bad++;
      $display("FAIL fetch_done: got done=%b data=%h want 1 00500093",
               i_done, i_rdata);
    end
    tick();
    n_cmp++;
    if (i_done !== 1'b0 || i_rdata !== 32'h0050_0093) begin
      n_bad++;
      $display("FAIL fetch_hold: got done=%b data=%h want 0 00500093",
               i_done, i_rdata);
    end
  endtask

  task automatic test_store_wait();
    d_addr = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    d_be = 4'hF;
    avm_waitrequest = 1'b1;
    d_wr = 1'b1;
    tick();
    d_wr = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({avm_write, avm_address, avm_writedata, avm_byteenable, d_done}
          !== {1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
        n_bad++;
        $display("FAIL store_stable[%0d]: got wr=%b a=%h d=%h be=%h dn=%b",
                 i, avm_write, avm_address, avm_writedata,
                 avm_byteenable, d_done);
      end
      if (i == 3) avm_waitrequest = 1'b0;
      tick();
    end
    n_cmp++;
    if ({d_done, i_done, avm_write} !== 3'b100) begin
      n_bad++;
      $display("FAIL store_done: got dd/id/wr=%b want 100",
               {d_done, i_done, avm_write});
    end
    tick();
    n_cmp++;
    if (d_done !== 1'b0) begin
      n_bad++;
      $display("FAIL store_pulse: got d_done=%b want 0", d_done);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] a;
    bit ok;
    do_reset();
    i_addr = 32'h80;
    d_addr = 32'h200;
    i_req = 1'b1;
    d_rd = 1'b1;
    tick();
    i_req = 1'b0;
    d_rd = 1'b0;
    serve_read(32'h1111_1111, a, ok);
    n_cmp++;
    if (!ok || a !== 32'h200 || d_done !== 1'b1 || i_done !== 1'b0
        || d_rdata !== 32'h1111_1111) begin
      n_bad++;
      $display("FAIL arb_first_data: got ok=%b a=%h dd=%b id=%b d=%h",
               ok, a, d_done, i_done, d_rdata);
    end
    serve_read(32'h2222_2222, a, ok);
    n_cmp++;
    if (!ok || a !== 32'h80 || i_done !== 1'b1
        || i_rdata !== 32'h2222_2222) begin
      n_bad++;
      $display("FAIL arb_second_instr: got ok=%b a=%h id=%b d=%h",
               ok, a, i_done, i_rdata);
    end
    tick();
    d_addr = 32'h204;
    d_rd = 1'b1;
    tick();
    d_rd = 1'b0;
    serve_read(32'h3333_3333, a, ok);
    n_cmp++;
    if (!ok || a !== 32'h204 || d_done !== 1'b1) begin
      n_bad++;
      $display("FAIL arb_lone_data: got ok=%b a=%h dd=%b", ok, a, d_done);
    end
    tick();
    i_addr = 32'h84;
    d_addr = 32'h208;
    i_req = 1'b1;
    d_rd = 1'b1;
    tick();
    i_req = 1'b0;
    d_rd = 1'b0;
    serve_read(32'h4444_4444, a, ok);
    n_cmp++;
    if (!ok || a !== 32'h84 || i_done !== 1'b1) begin
      n_bad++;
      $display("FAIL arb_instr_first: got ok=%b a=%h id=%b", ok, a, i_done);
    end
    serve_read(32'h5555_5555, a, ok);
    n_cmp++;
    if (!ok || a !== 32'h208 || d_done !== 1'b1
        || d_rdata !== 32'h5555_5555) begin
      n_bad++;
      $display("FAIL arb_data_second: got ok=%b a=%h dd=%b d=%h",
               ok, a, d_done, d_rdata);
    end
    tick();
  endtask

  task automatic test_level_req();
    int reads = 0;
    int dones = 0;
    logic prev_acc = 1'b0;
    i_addr = 32'h90;
    i_req = 1'b1;
    avm_readdata = 32'h0000_0113;
    for (int c = 0; c < 16; c++) begin
      if (c == 10) i_req = 1'b0;
      if (avm_read) reads++;
      if (i_done) dones++;
      avm_readdatavalid = prev_acc;
      prev_acc = avm_read & ~avm_waitrequest;
      tick();
    end
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    n_cmp++;
    if (reads != 1 || dones != 1) begin
      n_bad++;
      $display("FAIL level_once: got reads=%0d dones=%0d want 1 1",
               reads, dones);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    i_addr = 32'hA0;
    avm_waitrequest = 1'b1;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    tick();
    for (int k = 0; k < 30; k++) begin
      if (!avm_read) break;
      n++;
      tick();
    end
    n_cmp++;
    if (n != 8) begin
      n_bad++;
      $display("FAIL timeout_cycles: got %0d want 8", n);
    end
    n_cmp++;
    if (i_done !== 1'b1 || i_rdata !== 32'h0000_0013 || err !== 2'b01) begin
      n_bad++;
      $display("FAIL timeout_abort: got id=%b d=%h err=%b want 1 13 01",
               i_done, i_rdata, err);
    end
    avm_waitrequest = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (err !== 2'b01 || i_done !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_sticky: got err=%b id=%b want 01 0",
               err, i_done);
    end
    do_reset();
    n_cmp++;
    if (err !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_clear: got err=%b want 00", err);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    bit ok;
    logic [139:0] all;
    d_addr = 32'h300;
    d_rd = 1'b1;
    tick();
    d_rd = 1'b0;
    serve_read(32'h5555_AAAA, a, ok);
    n_cmp++;
    if (!ok || d_rdata !== 32'h5555_AAAA) begin
      n_bad++;
      $display("FAIL rstmid_load: got ok=%b d=%h want 5555aaaa",
               ok, d_rdata);
    end
    tick();
    d_addr = 32'h304;
    d_rd = 1'b1;
    tick();
    d_rd = 1'b0;
    tick();
    n_cmp++;
    if (avm_read !== 1'b1 || avm_address !== 32'h304) begin
      n_bad++;
      $display("FAIL rstmid_cmd: got rd=%b a=%h want 1 304",
               avm_read, avm_address);
    end
    tick();
    RST = 1'b1;
    tick();
    all = {avm_address, avm_writedata, i_rdata, d_rdata,
           avm_byteenable, avm_read, avm_write,
           i_done, d_done, err};
    n_cmp++;
    if (all !== '0) begin
      n_bad++;
      $display("FAIL rstmid_zero: got %h want 0", all);
    end
    RST = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hBADB_AD00;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({d_done, avm_read, d_rdata} !== 34'b0) begin
        n_bad++;
        $display("FAIL rstmid_late[%0d]: got dd=%b rd=%b d=%h want 0",
                 k, d_done, avm_read, d_rdata);
      end
      tick();
    end
  endtask

  task automatic test_rdwr_conflict();
    int reads = 0;
    int writes = 0;
    int dones = 0;
    logic [31:0] wa = '0;
    logic [31:0] wd = '0;
    logic [3:0]  wb = '0;
    d_addr = 32'h400;
    d_wdata = 32'hCAFE_F00D;
    d_be = 4'h3;
    d_rd = 1'b1;
    d_wr = 1'b1;
    tick();
    d_rd = 1'b0;
    d_wr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (avm_read) reads++;
      if (avm_write) begin
        writes++;
        wa = avm_address;
        wd = avm_writedata;
        wb = avm_byteenable;
      end
      if (d_done) dones++;
      tick();
    end
    n_cmp++;
    if (reads != 0 || writes != 1 || dones != 1) begin
      n_bad++;
      $display("FAIL conflict_ops: got r=%0d w=%0d d=%0d want 0 1 1",
               reads, writes, dones);
    end
    n_cmp++;
    if (wa !== 32'h400 || wd !== 32'hCAFE_F00D || wb !== 4'h3) begin
      n_bad++;
      $display("FAIL conflict_write: got a=%h d=%h be=%h", wa, wd, wb);
    end
    n_cmp++;
    if (err !== 2'b10) begin
      n_bad++;
      $display("FAIL conflict_err: got %b want 10", err);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_wait();
    test_arbitration();
    test_level_req();
    test_timeout();
    test_reset_mid();
    test_rdwr_conflict();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
